cache_fill_arbiter: RTL and testbench

Parametrised, multi-port cache-fill and write-through controller that sits between the processor's caches (port 0 = I-cache, port 1 = D-cache by convention) and the single shared main memory. It arbitrates miss and store requests round-robin, streams a whole cache block from the pipelined memory, steers each returned word to the owning cache's data array, and writes that cache's tag on the final word. It supersedes the per-cache fill FSM with configurable port count, block size and address stride.

---
 rtl/cache_fill_arbiter_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/cache_fill_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_arbiter_pkg
//  Description : Shared types and helpers for the cache fill / write-through
//                arbiter. Defines the controller state encoding, the port
//                index width helper and the block offset mask builder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_fill_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } fill_state_e;

  // Widest address the offset mask helper supports.
  localparam int MAX_ADDR_W = 32;

  // Port index width; a single requester still needs one bit of index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Ones in the low off_bits positions: the byte offset inside a block.
  function automatic logic [MAX_ADDR_W-1:0] block_offset_mask(input int off_bits);
    logic [MAX_ADDR_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if (i < off_bits) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Grants the first request
//                at or after the pointer, wrapping modulo NUM_PORTS.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid
);

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    int               w_pos;
    logic [IDX_W-1:0] w_sel;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_pos       = 0;
    w_sel       = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      w_pos = int'(ptr) + i;
      if (w_pos >= NUM_PORTS) w_pos = w_pos - NUM_PORTS;
      w_sel = IDX_W'(w_pos);
      if (req[w_sel]) begin
        grant        = '0;
        grant[w_sel] = 1'b1;
        grant_idx    = w_sel;
        grant_valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_arbiter
//  Description : Multi-port cache block fill and write-through controller.
//                Round-robin grants miss/store requests, streams a whole block
//                from pipelined memory and steers returns to the owning cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int BYTES_PER_WORD  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               miss_req,
  input  logic [NUM_PORTS*ADDR_W-1:0]        miss_addr,
  input  logic [NUM_PORTS-1:0]               wr_req,
  input  logic [NUM_PORTS*ADDR_W-1:0]        wr_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]        wr_data,
  output logic [NUM_PORTS-1:0]               fsm_busy,
  output logic [NUM_PORTS-1:0]               write_data_array,
  output logic [NUM_PORTS-1:0]               write_tag_array,
  output logic [NUM_PORTS-1:0]               wr_ack,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic [DATA_W-1:0]                  fill_data,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic                               mem_enable,
  output logic                               mem_wr,
  output logic [DATA_W-1:0]                  mem_data_in,
  input  logic [DATA_W-1:0]                  mem_data_out,
  input  logic                               mem_data_valid
);

  localparam int C_WORD_W   = $clog2(WORDS_PER_BLOCK);
  localparam int C_CNT_W    = C_WORD_W + 1;
  localparam int C_IDX_W    = idx_width(NUM_PORTS);
  localparam int C_OFF_BITS = $clog2(WORDS_PER_BLOCK * BYTES_PER_WORD);

  localparam logic [MAX_ADDR_W-1:0] C_OFF_MASK   = block_offset_mask(C_OFF_BITS);
  localparam logic [C_CNT_W-1:0]    C_ISSUE_END  = C_CNT_W'(WORDS_PER_BLOCK);
  localparam logic [C_WORD_W-1:0]   C_LAST_WORD  = C_WORD_W'(WORDS_PER_BLOCK - 1);
  localparam logic [C_IDX_W-1:0]    C_LAST_PORT  = C_IDX_W'(NUM_PORTS - 1);
  localparam logic [ADDR_W-1:0]     C_STRIDE     = ADDR_W'(BYTES_PER_WORD);

  fill_state_e          state_q,     state_d;
  logic [C_IDX_W-1:0]   ptr_q,       ptr_d;
  logic [C_IDX_W-1:0]   owner_q,     owner_d;
  logic [ADDR_W-1:0]    base_q,      base_d;
  logic [C_CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [C_WORD_W-1:0]  ret_cnt_q,   ret_cnt_d;

  logic [NUM_PORTS-1:0] w_grant;
  logic [C_IDX_W-1:0]   w_arb_idx;
  logic                 w_arb_valid;
  logic [NUM_PORTS-1:0] w_owner_oh;
  logic [ADDR_W-1:0]    w_block_keep;
  logic [ADDR_W-1:0]    w_issue_off;

  assign w_block_keep = ~C_OFF_MASK[ADDR_W-1:0];
  assign w_issue_off  = ADDR_W'(issue_cnt_q) * C_STRIDE;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (C_IDX_W)
  ) u_rr_arbiter (
    .req         (miss_req | wr_req),
    .ptr         (ptr_q),
    .grant       (w_grant),
    .grant_idx   (w_arb_idx),
    .grant_valid (w_arb_valid)
  );

  // One-hot of the port currently owning the memory.
  always_comb begin
    w_owner_oh = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_owner_oh[p] = (owner_q == C_IDX_W'(p));
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    owner_d          = owner_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    ret_cnt_d        = ret_cnt_q;
    fsm_busy         = '0;
    write_data_array = '0;
    write_tag_array  = '0;
    wr_ack           = '0;
    fill_word        = '0;
    fill_data        = '0;
    mem_addr         = '0;
    mem_enable       = 1'b0;
    mem_wr           = 1'b0;
    mem_data_in      = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_arb_valid) begin
          ptr_d       = (w_arb_idx == C_LAST_PORT) ? '0 : w_arb_idx + 1'b1;
          owner_d     = w_arb_idx;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          // A pending store goes ahead of a fill from the same port.
          if (|(wr_req & w_grant)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_FILL;
            base_d  = miss_addr[w_arb_idx*ADDR_W +: ADDR_W] & w_block_keep;
          end
        end
      end
      ST_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = wr_addr[owner_q*ADDR_W +: ADDR_W];
        mem_data_in = wr_data[owner_q*DATA_W +: DATA_W];
        wr_ack      = w_owner_oh;
        state_d     = ST_IDLE;
      end
      ST_FILL: begin
        fsm_busy = w_owner_oh;
        // Reads are issued back to back; returns are counted independently.
        if (issue_cnt_q < C_ISSUE_END) begin
          mem_enable  = 1'b1;
          mem_addr    = base_q + w_issue_off;
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (mem_data_valid) begin
          write_data_array = w_owner_oh;
          fill_word        = ret_cnt_q;
          fill_data        = mem_data_out;
          ret_cnt_d        = ret_cnt_q + 1'b1;
          if (ret_cnt_q == C_LAST_WORD) begin
            write_tag_array = w_owner_oh;
            ret_cnt_d       = '0;
            state_d         = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cache_fill_arbiter
//  Description : Self-checking bench: a transaction-level model predicts every
//                output each cycle; directed scenarios pin exact addresses,
//                word indices and cycle offsets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_arbiter;

  localparam int NP  = 2;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int WPB = 8;
  localparam int BPW = 2;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [NP-1:0]    miss_req, wr_req, fsm_busy, wda, wta, wr_ack;
  logic [NP*AW-1:0] miss_addr, wr_addr;
  logic [NP*DW-1:0] wr_data;
  logic [2:0]       fill_word;
  logic [DW-1:0]    fill_data, mem_data_in, mem_data_out;
  logic [AW-1:0]    mem_addr;
  logic             mem_enable, mem_wr, mem_data_valid;

  // Four-word-block instance
  logic [NP-1:0]    miss_req4, wr_req4, fsm_busy4, wda4, wta4, wr_ack4;
  logic [NP*AW-1:0] miss_addr4, wr_addr4;
  logic [NP*DW-1:0] wr_data4;
  logic [1:0]       fill_word4;
  logic [DW-1:0]    fill_data4, mem_data_in4, mem_data_out4;
  logic [AW-1:0]    mem_addr4;
  logic             mem_enable4, mem_wr4, mem_data_valid4;

  cache_fill_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
                       .WORDS_PER_BLOCK(WPB), .BYTES_PER_WORD(BPW)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .fsm_busy(fsm_busy), .write_data_array(wda), .write_tag_array(wta),
    .wr_ack(wr_ack), .fill_word(fill_word), .fill_data(fill_data),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid));

  cache_fill_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
                       .WORDS_PER_BLOCK(4), .BYTES_PER_WORD(BPW)) dut4 (
    .clk(clk), .rst(rst), .miss_req(miss_req4), .miss_addr(miss_addr4),
    .wr_req(wr_req4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .fsm_busy(fsm_busy4), .write_data_array(wda4), .write_tag_array(wta4),
    .wr_ack(wr_ack4), .fill_word(fill_word4), .fill_data(fill_data4),
    .mem_addr(mem_addr4), .mem_enable(mem_enable4), .mem_wr(mem_wr4),
    .mem_data_in(mem_data_in4), .mem_data_out(mem_data_out4),
    .mem_data_valid(mem_data_valid4));

  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  rd_t mq[$];
  rd_t mq4[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  // Transaction-level model: one outstanding job at a time
  bit            m_active = 1'b0;
  bit            m_store  = 1'b0;
  int            m_owner  = 0;
  int            m_ptr    = 0;
  int            m_start  = 0;
  int            m_rets   = 0;
  logic [AW-1:0] m_base   = '0;

  // Observation logs
  int            rd_cyc[$];
  logic [AW-1:0] rd_addr[$];
  int            st_cyc[$];
  int            st_port[$];
  int            st_word[$];
  logic [DW-1:0] st_data[$];
  int            tag_cyc[$];
  int            tag_port[$];
  int            tag_word[$];
  int            wr_cyc[$];
  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];
  int            wr_ackv[$];
  logic [AW-1:0] rd4_addr[$];
  int            st4_word[$];
  int            tag4_word[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete(); st_cyc.delete(); st_port.delete();
    st_word.delete(); st_data.delete(); tag_cyc.delete(); tag_port.delete();
    tag_word.delete(); wr_cyc.delete(); wr_a.delete(); wr_d.delete();
    wr_ackv.delete(); rd4_addr.delete(); st4_word.delete(); tag4_word.delete();
  endtask

  // Model prediction of this cycle's outputs compared against the DUT.
  task automatic compare();
    logic          e_en, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_fd;
    logic [NP-1:0] e_busy, e_wda, e_wta, e_ack;
    logic [2:0]    e_fw;
    int            off;
    e_en = 0; e_wr = 0; e_addr = '0; e_din = '0; e_fd = '0;
    e_busy = '0; e_wda = '0; e_wta = '0; e_ack = '0; e_fw = '0;
    if (m_active && m_store) begin
      e_en   = 1'b1;
      e_wr   = 1'b1;
      e_addr = wr_addr[m_owner*AW +: AW];
      e_din  = wr_data[m_owner*DW +: DW];
      e_ack  = NP'(1 << m_owner);
    end else if (m_active) begin
      off    = cyc - m_start;
      e_busy = NP'(1 << m_owner);
      if (off < WPB) begin
        e_en   = 1'b1;
        e_addr = AW'(m_base + off * BPW);
      end
      if (mem_data_valid) begin
        e_wda = NP'(1 << m_owner);
        e_fw  = 3'(m_rets);
        e_fd  = mem_data_out;
        if (m_rets == WPB - 1) e_wta = NP'(1 << m_owner);
      end
    end
    check("mem_enable",  32'(mem_enable),  32'(e_en));
    check("mem_wr",      32'(mem_wr),      32'(e_wr));
    check("mem_addr",    32'(mem_addr),    32'(e_addr));
    check("mem_data_in", 32'(mem_data_in), 32'(e_din));
    check("fsm_busy",    32'(fsm_busy),    32'(e_busy));
    check("write_data",  32'(wda),         32'(e_wda));
    check("write_tag",   32'(wta),         32'(e_wta));
    check("wr_ack",      32'(wr_ack),      32'(e_ack));
    check("fill_word",   32'(fill_word),   32'(e_fw));
    check("fill_data",   32'(fill_data),   32'(e_fd));
  endtask

  // One clock cycle: advance model, clock edge, drive memory, compare, log.
  task automatic tick();
    bit   found;
    int   p;
    rd_t  r;
    found = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_ptr    = 0;
    end else if (!m_active) begin
      for (int i = 0; i < NP; i++) begin
        p = (m_ptr + i) % NP;
        if (!found && (miss_req[p] || wr_req[p])) begin
          found    = 1'b1;
          m_active = 1'b1;
          m_owner  = p;
          m_ptr    = (p + 1) % NP;
          m_store  = wr_req[p];
          m_base   = miss_addr[p*AW +: AW] & ~AW'(WPB * BPW - 1);
          m_start  = cyc + 1;
          m_rets   = 0;
        end
      end
    end else if (m_store) begin
      m_active = 1'b0;
    end else if (mem_data_valid) begin
      m_rets++;
      if (m_rets == WPB) m_active = 1'b0;
    end

    @(posedge clk);
    cyc++;
    #1;
    mem_data_valid  = 1'b0;
    mem_data_out    = '0;
    mem_data_valid4 = 1'b0;
    mem_data_out4   = '0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      mem_data_valid = 1'b1;
      mem_data_out   = mq[0].data;
      void'(mq.pop_front());
    end
    if (mq4.size() > 0 && mq4[0].due == cyc) begin
      mem_data_valid4 = 1'b1;
      mem_data_out4   = mq4[0].data;
      void'(mq4.pop_front());
    end

    @(negedge clk);
    if (cmp_en) compare();

    if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(mem_addr);
      r.due  = cyc + LAT;
      r.data = mem_word(mem_addr);
      mq.push_back(r);
    end
    if (mem_enable === 1'b1 && mem_wr === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_data_in);
      wr_ackv.push_back(int'(wr_ack));
    end
    for (int q = 0; q < NP; q++) begin
      if (wda[q] === 1'b1) begin
        st_cyc.push_back(cyc);
        st_port.push_back(q);
        st_word.push_back(int'(fill_word));
        st_data.push_back(fill_data);
      end
      if (wta[q] === 1'b1) begin
        tag_cyc.push_back(cyc);
        tag_port.push_back(q);
        tag_word.push_back(int'(fill_word));
        miss_req[q] = 1'b0;
      end
      if (wr_ack[q] === 1'b1) wr_req[q] = 1'b0;
    end

    if (mem_enable4 === 1'b1 && mem_wr4 === 1'b0) begin
      rd4_addr.push_back(mem_addr4);
      r.due  = cyc + LAT;
      r.data = mem_word(mem_addr4);
      mq4.push_back(r);
    end
    if (wda4[0] === 1'b1) st4_word.push_back(int'(fill_word4));
    if (wta4[0] === 1'b1) begin
      tag4_word.push_back(int'(fill_word4));
      miss_req4[0] = 1'b0;
    end
  endtask

  // Run until the model is idle and no request is held, within a budget.
  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && (m_active || miss_req != '0 || wr_req != '0)) begin
      tick();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int t0;
    int n;
    miss_req = '0; wr_req = '0; miss_addr = '0; wr_addr = '0; wr_data = '0;
    mem_data_out = '0; mem_data_valid = 1'b0;
    miss_req4 = '0; wr_req4 = '0; miss_addr4 = '0; wr_addr4 = '0; wr_data4 = '0;
    mem_data_out4 = '0; mem_data_valid4 = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    check("reset_busy",    32'(fsm_busy),          32'd0);
    check("reset_mem_en",  32'(mem_enable),        32'd0);
    check("reset_strobes", 32'({wda, wta, wr_ack}), 32'd0);
    rst = 1'b0;
    tick();

    // Single fill from port 0, 4-cycle memory
    clear_logs();
    miss_addr[0 +: AW] = 16'h0036;
    miss_req[0] = 1'b1;
    t0 = cyc;
    wait_quiet("t1_done", 200);
    check("t1_nreads", 32'(rd_addr.size()), 32'd8);
    check("t1_nstrobes", 32'(st_word.size()), 32'd8);
    if (rd_addr.size() == 8 && st_word.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t1_addr",     32'(rd_addr[i]), 32'(16'h0030 + 2 * i));
        check("t1_addr_cyc", 32'(rd_cyc[i]),  32'(t0 + 1 + i));
        check("t1_word",     32'(st_word[i]), 32'(i));
        check("t1_port",     32'(st_port[i]), 32'd0);
        check("t1_data",     32'(st_data[i]), 32'(mem_word(AW'(16'h0030 + 2 * i))));
      end
      check("t1_tag_cyc", 32'(tag_cyc[0]), 32'(st_cyc[7]));
    end
    check("t1_tag_word", 32'(tag_word.size() > 0 ? tag_word[0] : -1), 32'd7);
    check("t1_busy_after", 32'(fsm_busy), 32'd0);

    // Both ports miss in the same cycle right after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
    miss_addr[0 +: AW]  = 16'h0010;
    miss_addr[AW +: AW] = 16'h2044;
    miss_req = 2'b11;
    wait_quiet("t2_done", 400);
    check("t2_nreads", 32'(rd_addr.size()), 32'd16);
    check("t2_nstrobes", 32'(st_port.size()), 32'd16);
    check("t2_ntags", 32'(tag_port.size()), 32'd2);
    if (rd_addr.size() == 16 && st_port.size() == 16 && tag_port.size() == 2) begin
      for (int i = 0; i < 8; i++) begin
        check("t2_addr_p0", 32'(rd_addr[i]),     32'(16'h0010 + 2 * i));
        check("t2_addr_p1", 32'(rd_addr[i + 8]), 32'(16'h2040 + 2 * i));
        check("t2_port_p0", 32'(st_port[i]),     32'd0);
        check("t2_port_p1", 32'(st_port[i + 8]), 32'd1);
      end
      check("t2_tag_order", 32'(tag_port[0]), 32'd0);
      check("t2_p1_start",  32'(rd_cyc[8]),   32'(tag_cyc[0] + 2));
    end

    // Store from port 1 while idle
    clear_logs();
    wr_addr[AW +: AW] = 16'h1000;
    wr_data[DW +: DW] = 16'hBEEF;
    wr_req[1] = 1'b1;
    t0 = cyc;
    wait_quiet("t3_done", 50);
    check("t3_nwrites", 32'(wr_a.size()), 32'd1);
    if (wr_a.size() == 1) begin
      check("t3_cyc",  32'(wr_cyc[0]),  32'(t0 + 1));
      check("t3_addr", 32'(wr_a[0]),    32'h1000);
      check("t3_data", 32'(wr_d[0]),    32'hBEEF);
      check("t3_ack",  32'(wr_ackv[0]), 32'd2);
    end
    check("t3_no_strobes", 32'(st_word.size() + tag_word.size() + rd_addr.size()), 32'd0);

    // Store and miss held together on port 1: store first, then fill
    clear_logs();
    miss_addr[AW +: AW] = 16'h1006;
    wr_req[1]   = 1'b1;
    miss_req[1] = 1'b1;
    t0 = cyc;
    wait_quiet("t4_done", 200);
    check("t4_nwrites", 32'(wr_cyc.size()), 32'd1);
    check("t4_nreads",  32'(rd_addr.size()), 32'd8);
    if (wr_cyc.size() == 1 && rd_addr.size() == 8) begin
      check("t4_wr_cyc",    32'(wr_cyc[0]),  32'(t0 + 1));
      check("t4_fill_cyc",  32'(rd_cyc[0]),  32'(t0 + 3));
      check("t4_first",     32'(rd_addr[0]), 32'h1000);
      check("t4_last",      32'(rd_addr[7]), 32'h100E);
    end
    check("t4_tag_port", 32'(tag_port.size() > 0 ? tag_port[0] : -1), 32'd1);

    // Reset after three returned words
    clear_logs();
    miss_addr[0 +: AW] = 16'h0400;
    miss_req[0] = 1'b1;
    n = 0;
    while (n < 60 && st_word.size() < 3) begin
      tick();
      n++;
    end
    check("t5_three_words", 32'(st_word.size()), 32'd3);
    rst = 1'b1;
    miss_req[0] = 1'b0;
    tick();
    check("t5_rst_mem_en", 32'(mem_enable), 32'd0);
    check("t5_rst_busy",   32'(fsm_busy),   32'd0);
    check("t5_rst_strobe", 32'({wda, wta}), 32'd0);
    rst = 1'b0;
    n = 0;
    while (n < 30 && mq.size() > 0) begin
      tick();
      n++;
    end
    tick();
    check("t5_no_late_strobes", 32'(st_word.size()), 32'd3);
    miss_addr[0 +: AW] = 16'h0500;
    miss_req[0] = 1'b1;
    wait_quiet("t5_done", 200);
    check("t5_restart_count", 32'(st_word.size()), 32'd11);
    check("t5_restart_word",  32'(st_word.size() > 3 ? st_word[3] : -1), 32'd0);
    check("t5_restart_tag",   32'(tag_word.size() > 0 ? tag_word[0] : -1), 32'd7);

    // Four-word blocks, unaligned miss address
    clear_logs();
    miss_addr4[0 +: AW] = 16'h00FF;
    miss_req4[0] = 1'b1;
    n = 0;
    while (n < 60 && miss_req4[0]) begin
      tick();
      n++;
    end
    check("t6_done",   32'(n < 60), 32'd1);
    check("t6_nreads", 32'(rd4_addr.size()), 32'd4);
    check("t6_nwords", 32'(st4_word.size()), 32'd4);
    if (rd4_addr.size() == 4 && st4_word.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t6_addr", 32'(rd4_addr[i]), 32'(16'h00F8 + 2 * i));
        check("t6_word", 32'(st4_word[i]), 32'(i));
      end
    end
    check("t6_tag_word", 32'(tag4_word.size() > 0 ? tag4_word[0] : -1), 32'd3);
    tick();
    check("t6_busy_after", 32'(fsm_busy4), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
